// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing control for the 5-stage pipeline:
// load-use stalls, jump flushes, mul/div hold and EX forwarding.
module pipe_hazard_ctrl #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RS1_D,
  input  logic [4:0]       RS2_D,
  input  logic [4:0]       RS1_E,
  input  logic [4:0]       RS2_E,
  input  logic [4:0]       RD_E,
  input  logic             ResultSrcE,
  input  logic [4:0]       RD_M,
  input  logic             RegWriteM,
  input  logic [4:0]       RD_W,
  input  logic             RegWriteW,
  input  logic             JumpD,
  input  logic             MdStartD,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MdBusy,
  output logic [CNT_W-1:0] StallCount
);

  localparam int CW = $clog2(MD_LAT) + 1;

  typedef enum logic {
    RUN,
    MDWAIT
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic            w_lwstall;

  assign w_lwstall = ResultSrcE && (RD_E != 5'd0) &&
                     ((RD_E == RS1_D) || (RD_E == RS2_D));

  // M stage result is newer than W, so it wins on a double match
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    if (we_m && (rd_m != 5'd0) && (rd_m == rs))
      return 2'b10;
    else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_cnt       <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (StallD)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    StallF      = 1'b0;
    StallD      = 1'b0;
    StallE      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    FlushM      = 1'b0;
    MdBusy      = 1'b0;
    ForwardAE   = 2'b00;
    ForwardBE   = 2'b00;
    if (!rst) begin
      ForwardAE = fwd_sel(RS1_E, RD_M, RegWriteM,
                          RD_W, RegWriteW);
      ForwardBE = fwd_sel(RS2_E, RD_M, RegWriteM,
                          RD_W, RegWriteW);
      unique case (r_state)
        RUN: begin
          if (w_lwstall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end else begin
            FlushD = JumpD;
            if (MdStartD) begin
              w_state_nxt = MDWAIT;
              w_cnt_nxt   = CW'(MD_LAT - 1);
            end
          end
        end
        MDWAIT: begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          FlushM = 1'b1;
          MdBusy = 1'b1;
          if (r_cnt == '0)
            w_state_nxt = RUN;
          else
            w_cnt_nxt = r_cnt - CW'(1);
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed cases plus
// random traffic against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int MD_LAT = 4;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1d;
    logic [4:0] rs2d;
    logic [4:0] rs1e;
    logic [4:0] rs2e;
    logic [4:0] rde;
    logic       rse;
    logic [4:0] rdm;
    logic       rwm;
    logic [4:0] rdw;
    logic       rww;
    logic       jmp;
    logic       md;
  } stim_t;

  typedef struct packed {
    logic        sf;
    logic        sd;
    logic        se;
    logic        fd;
    logic        fe;
    logic        fm;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        busy;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [4:0] RS1_D = '0, RS2_D = '0, RS1_E = '0, RS2_E = '0;
  logic [4:0] RD_E = '0, RD_M = '0, RD_W = '0;
  logic       ResultSrcE = 0, RegWriteM = 0, RegWriteW = 0;
  logic       JumpD = 0, MdStartD = 0;

  logic        sf, sd, se, fd, fe, fm, busy;
  logic [1:0]  fa, fb;
  logic [31:0] cnt;
  logic        sf4, sd4, se4, fd4, fe4, fm4, busy4;
  logic [1:0]  fa4, fb4;
  logic [3:0]  cnt4;

  pipe_hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .RS1_D(RS1_D), .RS2_D(RS2_D),
    .RS1_E(RS1_E), .RS2_E(RS2_E),
    .RD_E(RD_E), .ResultSrcE(ResultSrcE),
    .RD_M(RD_M), .RegWriteM(RegWriteM),
    .RD_W(RD_W), .RegWriteW(RegWriteW),
    .JumpD(JumpD), .MdStartD(MdStartD),
    .StallF(sf), .StallD(sd), .StallE(se),
    .FlushD(fd), .FlushE(fe), .FlushM(fm),
    .ForwardAE(fa), .ForwardBE(fb),
    .MdBusy(busy), .StallCount(cnt)
  );

  pipe_hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .RS1_D(RS1_D), .RS2_D(RS2_D),
    .RS1_E(RS1_E), .RS2_E(RS2_E),
    .RD_E(RD_E), .ResultSrcE(ResultSrcE),
    .RD_M(RD_M), .RegWriteM(RegWriteM),
    .RD_W(RD_W), .RegWriteW(RegWriteW),
    .JumpD(JumpD), .MdStartD(MdStartD),
    .StallF(sf4), .StallD(sd4), .StallE(se4),
    .FlushD(fd4), .FlushE(fe4), .FlushM(fm4),
    .ForwardAE(fa4), .ForwardBE(fb4),
    .MdBusy(busy4), .StallCount(cnt4)
  );

  exp_t q[$];
  int   vectors = 0;
  int   errors  = 0;

  // reference model state: cycles left in mul/div hold, stall total
  int          m_md_left = 0;
  logic [31:0] m_cnt = '0;

  function automatic logic [1:0] ref_fwd(input stim_t s,
                                         input logic [4:0] rs);
    if (s.rwm && s.rdm != 0 && s.rdm == rs) return 2'b10;
    if (s.rww && s.rdw != 0 && s.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t model(input stim_t s);
    exp_t e;
    bit   lw;
    e = '0;
    e.cnt = m_cnt;
    if (s.rst) begin
      m_md_left = 0;
      m_cnt = '0;
      return e;
    end
    e.fa = ref_fwd(s, s.rs1e);
    e.fb = ref_fwd(s, s.rs2e);
    lw = s.rse && s.rde != 0 &&
         (s.rde == s.rs1d || s.rde == s.rs2d);
    if (m_md_left > 0) begin
      {e.sf, e.sd, e.se, e.fm, e.busy} = 5'b11111;
      m_md_left--;
    end else if (lw) begin
      {e.sf, e.sd, e.fe} = 3'b111;
    end else begin
      e.fd = s.jmp;
      if (s.md) m_md_left = MD_LAT;
    end
    if (e.sd) m_cnt = m_cnt + 1;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    rst = s.rst;
    RS1_D = s.rs1d; RS2_D = s.rs2d;
    RS1_E = s.rs1e; RS2_E = s.rs2e;
    RD_E = s.rde; ResultSrcE = s.rse;
    RD_M = s.rdm; RegWriteM = s.rwm;
    RD_W = s.rdw; RegWriteW = s.rww;
    JumpD = s.jmp; MdStartD = s.md;
    q.push_back(model(s));
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=%0h want=%0h",
               nm, vectors, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      chk("StallF", 32'(sf), 32'(e.sf));
      chk("StallD", 32'(sd), 32'(e.sd));
      chk("StallE", 32'(se), 32'(e.se));
      chk("FlushD", 32'(fd), 32'(e.fd));
      chk("FlushE", 32'(fe), 32'(e.fe));
      chk("FlushM", 32'(fm), 32'(e.fm));
      chk("ForwardAE", 32'(fa), 32'(e.fa));
      chk("ForwardBE", 32'(fb), 32'(e.fb));
      chk("MdBusy", 32'(busy), 32'(e.busy));
      chk("StallCount", cnt, e.cnt);
      chk("StallD_w4", 32'(sd4), 32'(e.sd));
      chk("FlushD_w4", 32'(fd4), 32'(e.fd));
      chk("MdBusy_w4", 32'(busy4), 32'(e.busy));
      chk("Fwd_w4", 32'({fa4, fb4}), 32'({e.fa, e.fb}));
      chk("Misc_w4", 32'({sf4, se4, fe4, fm4}),
          32'({e.sf, e.se, e.fe, e.fm}));
      chk("StallCount_w4", 32'(cnt4), 32'(e.cnt[3:0]));
    end
  end

  function automatic stim_t rnd();
    stim_t s;
    s.rst  = ($urandom_range(0, 49) == 0);
    s.rs1d = 5'($urandom_range(0, 7));
    s.rs2d = 5'($urandom_range(0, 7));
    s.rs1e = 5'($urandom_range(0, 7));
    s.rs2e = 5'($urandom_range(0, 7));
    s.rde  = 5'($urandom_range(0, 7));
    s.rse  = ($urandom_range(0, 2) == 0);
    s.rdm  = 5'($urandom_range(0, 7));
    s.rwm  = 1'($urandom);
    s.rdw  = 5'($urandom_range(0, 7));
    s.rww  = 1'($urandom);
    s.jmp  = ($urandom_range(0, 3) == 0);
    s.md   = ($urandom_range(0, 7) == 0);
    return s;
  endfunction

  initial begin
    stim_t s;
    repeat (2) @(posedge clk);
    #1;
    s = '0; s.rst = 1;
    drive(s); drive(s);
    // load-use, then RD_E=0 gives no stall
    s = '0; s.rse = 1; s.rde = 5; s.rs2d = 5;
    drive(s);
    s.rde = 0; s.rs2d = 0;
    drive(s);
    // jump alone; jump behind a load-use stall
    s = '0; s.jmp = 1;
    drive(s);
    s.rse = 1; s.rde = 7; s.rs1d = 7;
    drive(s);
    s.rse = 0;
    drive(s);
    // mul/div with a stray jump in cycle 2
    s = '0; s.md = 1;
    drive(s);
    s.md = 0;
    for (int i = 1; i <= 6; i++) begin
      s.jmp = (i == 2);
      drive(s);
    end
    // forwarding priority
    s = '0; s.rs1e = 3; s.rs2e = 3;
    s.rdm = 3; s.rwm = 1; s.rdw = 3; s.rww = 1;
    drive(s);
    s.rwm = 0;
    drive(s);
    s.rdw = 0;
    drive(s);
    // reset in the middle of a mul/div hold
    s = '0; s.md = 1;
    drive(s);
    s.md = 0;
    drive(s);
    s.rst = 1;
    drive(s);
    s.rst = 0;
    drive(s); drive(s);
    // long load-use hold wraps the 4-bit counter
    s = '0; s.rst = 1;
    drive(s);
    s = '0; s.rse = 1; s.rde = 9; s.rs1d = 9;
    for (int i = 0; i < 18; i++) drive(s);
    for (int i = 0; i < 3000; i++) drive(rnd());
    s = '0;
    drive(s);
    for (int i = 0; i < 4 && q.size() > 0; i++)
      @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
